bg_pixel_formatter_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-layer BG pixel formatter.
- Formats NUM_BG background layers in parallel into the standard 20-bit layer word.
- Resolves the highest-priority visible layer and tracks the horizontal pixel position.
- Sits between the per-layer BG fetch units and the object/BG compositor, with valid/ready flow control on both sides.

---
 rtl/bg_pixel_formatter_pipe.sv | 141 ++++++++++++++
 tb/tb_bg_pixel_formatter_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_pixel_formatter_pipe.sv
// Two-stage pipelined BG pixel formatter: formats NUM_BG layers into 20-bit words,
// resolves the top visible layer and tracks the output pixel position with valid/ready flow control.
module bg_pixel_formatter_pipe #(
    parameter int NUM_BG      = 4,
    parameter int LINE_PIXELS = 240,
    parameter int XW          = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15*NUM_BG-1:0]   data,
    input  logic [NUM_BG-1:0]      sixteen_color_dot_select,
    input  logic [NUM_BG-1:0]      palettemode,
    input  logic [NUM_BG-1:0]      bitmapped,
    input  logic [NUM_BG-1:0]      transparent,
    input  logic [4*NUM_BG-1:0]    paletteno,
    input  logic [2*NUM_BG-1:0]    bg_priority,
    input  logic [NUM_BG-1:0]      bgused,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [20*NUM_BG-1:0]   formatted,
    output logic [19:0]            top_formatted,
    output logic [1:0]             top_bgno,
    output logic                   any_visible,
    output logic [XW-1:0]          pixel_x,
    output logic                   line_end
);

    localparam logic [XW-1:0] LAST_X = XW'(LINE_PIXELS - 1);

    logic                  s1_valid;
    logic [20*NUM_BG-1:0]  s1_words;
    logic [20*NUM_BG-1:0]  fmt_next;
    logic                  s1_adv;
    logic                  s2_adv;

    logic                  win_found;
    logic [1:0]            win_prio;
    logic [1:0]            win_idx;
    logic [19:0]           win_word;

    function automatic logic [19:0] format_word(
        input logic [14:0] d,
        input logic        sel,
        input logic        pm,
        input logic        bm,
        input logic        tr,
        input logic [3:0]  pno,
        input logic [1:0]  prio,
        input logic        used,
        input logic [1:0]  bgno
    );
        logic [3:0]  nib;
        logic [7:0]  pidx;
        logic [7:0]  pinfo;
        logic        vis;
        logic [14:0] payload;
        nib     = sel ? d[7:4] : d[3:0];
        pidx    = pm ? d[7:0] : {4'b0, nib};
        vis     = ((|pidx) | bm) & used & ~tr;
        pinfo   = pm ? pidx : {pno, pidx[3:0]};
        payload = bm ? d : {4'b0, bgno, 1'b0, pinfo};
        return {prio, 1'b0, bm, vis, payload};
    endfunction

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign line_end = out_valid & (pixel_x == LAST_X);

    always_comb begin
        fmt_next = '0;
        for (int i = 0; i < NUM_BG; i++) begin
            fmt_next[20*i +: 20] = format_word(data[15*i +: 15],
                                               sixteen_color_dot_select[i],
                                               palettemode[i],
                                               bitmapped[i],
                                               transparent[i],
                                               paletteno[4*i +: 4],
                                               bg_priority[2*i +: 2],
                                               bgused[i],
                                               2'(i));
        end
    end

    // Strict less-than while scanning upward keeps ties on the lowest layer index.
    always_comb begin
        win_found = 1'b0;
        win_prio  = '0;
        win_idx   = '0;
        win_word  = '0;
        for (int i = 0; i < NUM_BG; i++) begin
            if (s1_words[20*i + 15] && (!win_found || (s1_words[20*i + 18 +: 2] < win_prio))) begin
                win_found = 1'b1;
                win_prio  = s1_words[20*i + 18 +: 2];
                win_idx   = 2'(i);
                win_word  = s1_words[20*i +: 20];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_words <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_words <= fmt_next;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            formatted     <= '0;
            top_formatted <= '0;
            top_bgno      <= '0;
            any_visible   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                formatted     <= s1_words;
                top_formatted <= win_word;
                top_bgno      <= win_idx;
                any_visible   <= win_found;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x <= '0;
        end else if (out_valid && out_ready) begin
            pixel_x <= (pixel_x == LAST_X) ? '0 : pixel_x + 1'b1;
        end
    end

endmodule

// File: tb/tb_bg_pixel_formatter_pipe.sv
// Directed bench for bg_pixel_formatter_pipe: table-driven format/priority vectors
// plus hand-written stall, mid-stream reset and scanline wrap sequences.
module tb_bg_pixel_formatter_pipe;

    localparam int NUM_BG      = 4;
    localparam int LINE_PIXELS = 240;
    localparam int XW          = 8;

    logic                  clock;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [15*NUM_BG-1:0]  data;
    logic [NUM_BG-1:0]     sixteen_color_dot_select;
    logic [NUM_BG-1:0]     palettemode;
    logic [NUM_BG-1:0]     bitmapped;
    logic [NUM_BG-1:0]     transparent;
    logic [4*NUM_BG-1:0]   paletteno;
    logic [2*NUM_BG-1:0]   bg_priority;
    logic [NUM_BG-1:0]     bgused;
    logic                  out_valid;
    logic                  out_ready;
    logic [20*NUM_BG-1:0]  formatted;
    logic [19:0]           top_formatted;
    logic [1:0]            top_bgno;
    logic                  any_visible;
    logic [XW-1:0]         pixel_x;
    logic                  line_end;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [59:0]  data;
        logic [3:0]   sel;
        logic [3:0]   pm;
        logic [3:0]   bm;
        logic [3:0]   tr;
        logic [15:0]  pno;
        logic [7:0]   prio;
        logic [3:0]   used;
        logic [79:0]  exp_fmt;
        logic [19:0]  exp_top;
        logic [1:0]   exp_bgno;
        logic         exp_any;
    } vec_t;

    vec_t vecs[6];

    bg_pixel_formatter_pipe #(
        .NUM_BG(NUM_BG),
        .LINE_PIXELS(LINE_PIXELS),
        .XW(XW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data(data),
        .sixteen_color_dot_select(sixteen_color_dot_select),
        .palettemode(palettemode),
        .bitmapped(bitmapped),
        .transparent(transparent),
        .paletteno(paletteno),
        .bg_priority(bg_priority),
        .bgused(bgused),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .formatted(formatted),
        .top_formatted(top_formatted),
        .top_bgno(top_bgno),
        .any_visible(any_visible),
        .pixel_x(pixel_x),
        .line_end(line_end)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        data                     = v.data;
        sixteen_color_dot_select = v.sel;
        palettemode              = v.pm;
        bitmapped                = v.bm;
        transparent              = v.tr;
        paletteno                = v.pno;
        bg_priority              = v.prio;
        bgused                   = v.used;
    endtask

    // Only layer 0 is live, in 256-colour mode, so its word is 0x08000 | low byte.
    task automatic drive_l0_slice(input logic [7:0] val);
        data                     = {45'h0, 7'h0, val};
        sixteen_color_dot_select = '0;
        palettemode              = 4'b0001;
        bitmapped                = '0;
        transparent              = '0;
        paletteno                = '0;
        bg_priority              = '0;
        bgused                   = 4'b0001;
    endtask

    initial begin
        vecs[0] = '{"nib_hi_pal16", {15'h0, 15'h0, 15'h0, 15'h00A5}, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                    {4'h0, 4'h0, 4'h0, 4'h3}, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0001,
                    {20'h00600, 20'h00400, 20'h00200, 20'h8803A}, 20'h8803A, 2'd0, 1'b1};
        vecs[1] = '{"pal256_zero_bitmap_zero", {15'h0, 15'h0, 15'h7F00, 15'h0}, 4'b0000, 4'b0010, 4'b0100, 4'b0000,
                    {4'h0, 4'h0, 4'h5, 4'h0}, {2'd0, 2'd3, 2'd1, 2'd0}, 4'b0110,
                    {20'h00600, 20'hD8000, 20'h40200, 20'h00000}, 20'hD8000, 2'd2, 1'b1};
        vecs[2] = '{"prio_3112", {15'h0044, 15'h0033, 15'h0022, 15'h0011}, 4'b0000, 4'b1111, 4'b0000, 4'b0000,
                    16'h0, {2'd2, 2'd1, 2'd1, 2'd3}, 4'b1111,
                    {20'h88644, 20'h48433, 20'h48222, 20'hC8011}, 20'h48222, 2'd1, 1'b1};
        vecs[3] = '{"all_transparent", {15'h0044, 15'h0033, 15'h0022, 15'h0011}, 4'b0000, 4'b1111, 4'b0000, 4'b1111,
                    16'h0, {2'd2, 2'd1, 2'd1, 2'd3}, 4'b1111,
                    {20'h80644, 20'h40433, 20'h40222, 20'hC0011}, 20'h00000, 2'd0, 1'b0};
        vecs[4] = '{"bitmap_unused_tie", {15'h7FFF, 15'h00F7, 15'h00F0, 15'h1234}, 4'b0000, 4'b0000, 4'b1001, 4'b0000,
                    {4'h0, 4'hC, 4'hA, 4'h0}, {2'd2, 2'd2, 2'd0, 2'd0}, 4'b1110,
                    {20'h9FFFF, 20'h884C7, 20'h002A0, 20'h11234}, 20'h884C7, 2'd2, 1'b1};
        vecs[5] = '{"only_layer3", {15'h0001, 15'h00FF, 15'h00FF, 15'h00FF}, 4'b0000, 4'b1111, 4'b0000, 4'b0111,
                    16'h0, {2'd3, 2'd0, 2'd0, 2'd0}, 4'b1111,
                    {20'hC8601, 20'h004FF, 20'h002FF, 20'h000FF}, 20'hC8601, 2'd3, 1'b1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        apply_stimulus(vecs[0]);
        #1;
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_pixel_x", pixel_x, 0);
        check_output("rst_formatted", formatted, 0);
        check_output("rst_in_ready", in_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;

        // Format and priority vectors, each checked for exact 2-cycle latency.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            apply_stimulus(vecs[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check_output({vecs[i].name, "_in_ready"}, in_ready, 1);
            @(negedge clock);
            in_valid = 1'b0;
            check_output({vecs[i].name, "_lat1_valid"}, out_valid, 0);
            @(negedge clock);
            check_output({vecs[i].name, "_lat2_valid"}, out_valid, 1);
            check_output({vecs[i].name, "_formatted"}, formatted, vecs[i].exp_fmt);
            check_output({vecs[i].name, "_top_formatted"}, top_formatted, vecs[i].exp_top);
            check_output({vecs[i].name, "_top_bgno"}, top_bgno, vecs[i].exp_bgno);
            check_output({vecs[i].name, "_any_visible"}, any_visible, vecs[i].exp_any);
        end

        // Five slices with out_ready held low for three cycles after the pipe fills.
        begin
            int sent = 0;
            int recv = 0;
            logic held_valid = 1'b0;
            logic saw_drop = 1'b0;
            logic [79:0] held_fmt = '0;
            for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
                @(negedge clock);
                out_ready = !(cyc >= 2 && cyc <= 4);
                in_valid  = (sent < 5);
                drive_l0_slice(8'(sent + 1));
                #1;
                if (held_valid) check_output("stall_hold", formatted, held_fmt);
                if (!in_ready && !saw_drop) begin
                    saw_drop = 1'b1;
                    check_output("stall_drop_depth", sent, 2);
                end
                held_valid = out_valid && !out_ready;
                held_fmt   = formatted;
                if (out_valid && out_ready) begin
                    check_output("stall_order", formatted[19:0], 20'h08000 + 20'(recv + 1));
                    recv++;
                end
                if (in_valid && in_ready) sent++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check_output("stall_recv_count", recv, 5);
            check_output("stall_saw_drop", saw_drop, 1);
        end

        // Two slices in flight, then asynchronous reset between clock edges.
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_l0_slice(8'h55);
        @(negedge clock);
        drive_l0_slice(8'h66);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check_output("mid_pre_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check_output("mid_rst_out_valid", out_valid, 0);
        check_output("mid_rst_pixel_x", pixel_x, 0);
        check_output("mid_rst_formatted", formatted, 0);
        check_output("mid_rst_top_formatted", top_formatted, 0);
        check_output("mid_rst_top_bgno", top_bgno, 0);
        check_output("mid_rst_any_visible", any_visible, 0);
        check_output("mid_rst_line_end", line_end, 0);
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        check_output("mid_rel_in_ready", in_ready, 1);
        @(negedge clock);
        check_output("mid_rel_no_leftover", out_valid, 0);

        // Full-rate scanline plus two, checking wrap and line_end placement.
        begin
            int sent = 0;
            int recv = 0;
            int exp_x = 0;
            int le_count = 0;
            for (int cyc = 0; cyc < 400 && recv < LINE_PIXELS + 2; cyc++) begin
                @(negedge clock);
                out_ready = 1'b1;
                in_valid  = (sent < LINE_PIXELS + 2);
                drive_l0_slice(8'(sent));
                #1;
                if (out_valid) begin
                    check_output("line_end_flag", line_end, (exp_x == LINE_PIXELS - 1) ? 1 : 0);
                    check_output("line_pixel_x", pixel_x, exp_x);
                    if (line_end) le_count++;
                end
                if (out_valid && out_ready) begin
                    recv++;
                    exp_x = (exp_x == LINE_PIXELS - 1) ? 0 : exp_x + 1;
                end
                if (in_valid && in_ready) sent++;
            end
            in_valid = 1'b0;
            check_output("line_recv_count", recv, LINE_PIXELS + 2);
            check_output("line_end_count", le_count, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
